// File: rtl/instr_decode_pkg.sv
// Core-wide types and constants used by the decode stage.
// Holds the datapath widths, the register-file read request type, the
// decoded-operation bundle, the ALU operation encoding and the RV32I
// opcode / funct3 / funct7 constants.
package instr_decode_pkg;

  localparam int unsigned cXLEN       = 32;
  localparam int unsigned cRegSelBitW = 5;

  // Register-file read request: dv=0 makes the register file return zero.
  typedef struct packed {
    logic                   dv;
    logic [cRegSelBitW-1:0] addr;
  } tRegOp;

  typedef enum logic [3:0] {
    AluAdd,
    AluSub,
    AluSll,
    AluSlt,
    AluSltu,
    AluXor,
    AluSrl,
    AluSra,
    AluOr,
    AluAnd
  } tAluOp;

  typedef struct packed {
    logic [cXLEN-1:0]       pc;
    logic [cRegSelBitW-1:0] rdAddr;
    logic                   rdWe;
    tAluOp                  aluOp;
    logic [cXLEN-1:0]       imm;
    logic                   useImm;
    logic                   useRs1;
    logic                   useRs2;
    logic                   isLoad;
    logic                   isStore;
    logic                   isBranch;
    logic                   isJal;
    logic                   isJalr;
    logic                   isLui;
    logic                   isAuipc;
    logic [2:0]             funct3;
    logic                   illegal;
  } tDecOp;

  // Major opcodes (instruction bits 6:0).
  localparam logic [6:0] cOpLui    = 7'b0110111;
  localparam logic [6:0] cOpAuipc  = 7'b0010111;
  localparam logic [6:0] cOpJal    = 7'b1101111;
  localparam logic [6:0] cOpJalr   = 7'b1100111;
  localparam logic [6:0] cOpBranch = 7'b1100011;
  localparam logic [6:0] cOpLoad   = 7'b0000011;
  localparam logic [6:0] cOpStore  = 7'b0100011;
  localparam logic [6:0] cOpOpImm  = 7'b0010011;
  localparam logic [6:0] cOpOp     = 7'b0110011;
  localparam logic [6:0] cOpFence  = 7'b0001111;

  // ALU funct3 values (OP / OP-IMM).
  localparam logic [2:0] cF3AddSub = 3'b000;
  localparam logic [2:0] cF3Sll    = 3'b001;
  localparam logic [2:0] cF3Slt    = 3'b010;
  localparam logic [2:0] cF3Sltu   = 3'b011;
  localparam logic [2:0] cF3Xor    = 3'b100;
  localparam logic [2:0] cF3SrlSra = 3'b101;
  localparam logic [2:0] cF3Or     = 3'b110;
  localparam logic [2:0] cF3And    = 3'b111;

  // Load / store / jalr funct3 values.
  localparam logic [2:0] cF3Lb   = 3'b000;
  localparam logic [2:0] cF3Lh   = 3'b001;
  localparam logic [2:0] cF3Lw   = 3'b010;
  localparam logic [2:0] cF3Lbu  = 3'b100;
  localparam logic [2:0] cF3Lhu  = 3'b101;
  localparam logic [2:0] cF3Sw   = 3'b010;
  localparam logic [2:0] cF3Jalr = 3'b000;

  // Branch funct3 encodings with no defined instruction.
  localparam logic [2:0] cF3BrRsv0 = 3'b010;
  localparam logic [2:0] cF3BrRsv1 = 3'b011;

  localparam logic [6:0] cF7Base = 7'b0000000;
  localparam logic [6:0] cF7Alt  = 7'b0100000;

  // alt selects SUB over ADD and SRA over SRL; ignored for other funct3.
  function automatic tAluOp aluFromFunct3(input logic [2:0] f3, input logic alt);
    tAluOp op;
    case (f3)
      cF3AddSub: op = alt ? AluSub : AluAdd;
      cF3Sll:    op = AluSll;
      cF3Slt:    op = AluSlt;
      cF3Sltu:   op = AluSltu;
      cF3Xor:    op = AluXor;
      cF3SrlSra: op = alt ? AluSra : AluSrl;
      cF3Or:     op = AluOr;
      default:   op = AluAnd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/instr_decode_imm_gen.sv
// Immediate generator for the decode stage.
// Selects the immediate format from the opcode and sign-extends it to pXLEN.
//   iInstr  raw 32-bit instruction word
//   oImm    sign-extended immediate (U-type: imm[31:12] followed by 12 zeros,
//           zero for formats without an immediate)
module instr_decode_imm_gen
  import instr_decode_pkg::*;
#(
  parameter int unsigned pXLEN = cXLEN
) (
  input  logic [31:0]      iInstr,
  output logic [pXLEN-1:0] oImm
);

  logic signed [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (iInstr[6:0])
      cOpLui, cOpAuipc: imm32 = {iInstr[31:12], 12'b0};
      cOpJal:           imm32 = {{11{iInstr[31]}}, iInstr[31], iInstr[19:12], iInstr[20],
                                 iInstr[30:21], 1'b0};
      cOpBranch:        imm32 = {{19{iInstr[31]}}, iInstr[31], iInstr[7], iInstr[30:25],
                                 iInstr[11:8], 1'b0};
      cOpStore:         imm32 = {{20{iInstr[31]}}, iInstr[31:25], iInstr[11:7]};
      cOpJalr, cOpLoad, cOpOpImm:
                        imm32 = {{20{iInstr[31]}}, iInstr[31:20]};
      default:          imm32 = '0;
    endcase
  end

  // Signed size cast sign-extends when pXLEN exceeds 32.
  assign oImm = pXLEN'(imm32);

endmodule

// File: rtl/instr_decode.sv
// RV32I decode stage with a single-entry output pipeline register.
//   iClk / iRst       core clock, asynchronous active-low reset
//   iValid / oReady   fetch handshake carrying iInstr and iPc
//   iFlush            drops both the held op and the incoming word
//   oValid / iReady   execute handshake carrying oDec
//   oDec              registered decoded-operation bundle
//   oRs1 / oRs2       registered register-file read requests, aligned with oDec
module instr_decode
  import instr_decode_pkg::*;
#(
  parameter int unsigned pXLEN       = cXLEN,
  parameter int unsigned pRegSelBitW = cRegSelBitW
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iValid,
  output logic             oReady,
  input  logic [31:0]      iInstr,
  input  logic [pXLEN-1:0] iPc,
  input  logic             iFlush,
  output logic             oValid,
  input  logic             iReady,
  output tDecOp            oDec,
  output tRegOp            oRs1,
  output tRegOp            oRs2
);

  // The bundle and request types are sized by the package widths.
  if (pXLEN != cXLEN || pRegSelBitW != cRegSelBitW) begin : gBadParams
    $error("instr_decode: pXLEN/pRegSelBitW must match cXLEN/cRegSelBitW");
  end

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [4:0]       rdF;
  logic [4:0]       rs1F;
  logic [4:0]       rs2F;
  logic [pXLEN-1:0] imm;

  assign opcode = iInstr[6:0];
  assign rdF    = iInstr[11:7];
  assign funct3 = iInstr[14:12];
  assign rs1F   = iInstr[19:15];
  assign rs2F   = iInstr[24:20];
  assign funct7 = iInstr[31:25];

  instr_decode_imm_gen #(
    .pXLEN(pXLEN)
  ) uImmGen (
    .iInstr(iInstr),
    .oImm  (imm)
  );

  // Control decode of the incoming word.
  tDecOp decNew;
  tRegOp rs1New;
  tRegOp rs2New;
  logic  illegal;
  logic  hasRd;
  logic  isShift;

  always_comb begin
    decNew        = '0;
    decNew.pc     = iPc;
    decNew.rdAddr = rdF;
    decNew.funct3 = funct3;
    decNew.imm    = imm;
    decNew.aluOp  = AluAdd;
    illegal       = 1'b0;
    hasRd         = 1'b0;
    isShift       = (funct3 == cF3Sll) || (funct3 == cF3SrlSra);
    // Every listed opcode ends in 2'b11, so iInstr[1:0] != 2'b11 lands in default.
    case (opcode)
      cOpLui: begin
        hasRd         = 1'b1;
        decNew.useImm = 1'b1;
        decNew.isLui  = 1'b1;
      end
      cOpAuipc: begin
        hasRd          = 1'b1;
        decNew.useImm  = 1'b1;
        decNew.isAuipc = 1'b1;
      end
      cOpJal: begin
        hasRd         = 1'b1;
        decNew.useImm = 1'b1;
        decNew.isJal  = 1'b1;
      end
      cOpJalr: begin
        hasRd         = 1'b1;
        decNew.useRs1 = 1'b1;
        decNew.useImm = 1'b1;
        decNew.isJalr = 1'b1;
        illegal       = (funct3 != cF3Jalr);
      end
      cOpBranch: begin
        decNew.useRs1   = 1'b1;
        decNew.useRs2   = 1'b1;
        decNew.isBranch = 1'b1;
        decNew.aluOp    = AluSub;
        illegal         = (funct3 == cF3BrRsv0) || (funct3 == cF3BrRsv1);
      end
      cOpLoad: begin
        hasRd         = 1'b1;
        decNew.useRs1 = 1'b1;
        decNew.useImm = 1'b1;
        decNew.isLoad = 1'b1;
        illegal       = !(funct3 inside {cF3Lb, cF3Lh, cF3Lw, cF3Lbu, cF3Lhu});
      end
      cOpStore: begin
        decNew.useRs1  = 1'b1;
        decNew.useRs2  = 1'b1;
        decNew.useImm  = 1'b1;
        decNew.isStore = 1'b1;
        illegal        = (funct3 > cF3Sw);
      end
      cOpOpImm: begin
        hasRd         = 1'b1;
        decNew.useRs1 = 1'b1;
        decNew.useImm = 1'b1;
        // Only shifts carry a funct7 field; other OP-IMM words use those bits as imm.
        decNew.aluOp  = aluFromFunct3(funct3, (funct3 == cF3SrlSra) && funct7[5]);
        if (isShift) begin
          illegal = !((funct7 == cF7Base) || (funct7 == cF7Alt && funct3 == cF3SrlSra));
        end
      end
      cOpOp: begin
        hasRd         = 1'b1;
        decNew.useRs1 = 1'b1;
        decNew.useRs2 = 1'b1;
        decNew.aluOp  = aluFromFunct3(funct3, funct7 == cF7Alt);
        illegal       = !((funct7 == cF7Base) ||
                          (funct7 == cF7Alt &&
                           (funct3 == cF3AddSub || funct3 == cF3SrlSra)));
      end
      cOpFence: begin
        // Executes as a NOP in this in-order core.
      end
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      hasRd           = 1'b0;
      decNew.useRs1   = 1'b0;
      decNew.useRs2   = 1'b0;
      decNew.isLoad   = 1'b0;
      decNew.isStore  = 1'b0;
      decNew.isBranch = 1'b0;
      decNew.isJal    = 1'b0;
      decNew.isJalr   = 1'b0;
      decNew.isLui    = 1'b0;
      decNew.isAuipc  = 1'b0;
    end
    decNew.illegal = illegal;
    decNew.rdWe    = hasRd && (rdF != '0);

    // x0 reads are suppressed here so the register file never depends on rf[0].
    rs1New.addr = rs1F;
    rs1New.dv   = decNew.useRs1 && (rs1F != '0);
    rs2New.addr = rs2F;
    rs2New.dv   = decNew.useRs2 && (rs2F != '0);
  end

  // Output pipeline register.
  logic  validQ;
  logic  validD;
  tDecOp decQ;
  tDecOp decD;
  tRegOp rs1Q;
  tRegOp rs1D;
  tRegOp rs2Q;
  tRegOp rs2D;
  logic  accept;
  logic  xferOut;

  assign oReady  = !validQ || iReady;
  assign accept  = iValid && oReady;
  assign xferOut = validQ && iReady;

  always_comb begin
    validD = validQ;
    decD   = decQ;
    rs1D   = rs1Q;
    rs2D   = rs2Q;
    if (iFlush) begin
      validD  = 1'b0;
      rs1D.dv = 1'b0;
      rs2D.dv = 1'b0;
    end else if (accept) begin
      validD = 1'b1;
      decD   = decNew;
      rs1D   = rs1New;
      rs2D   = rs2New;
    end else if (xferOut) begin
      validD  = 1'b0;
      rs1D.dv = 1'b0;
      rs2D.dv = 1'b0;
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      validQ <= 1'b0;
      decQ   <= '0;
      rs1Q   <= '0;
      rs2Q   <= '0;
    end else begin
      validQ <= validD;
      decQ   <= decD;
      rs1Q   <= rs1D;
      rs2Q   <= rs2D;
    end
  end

  assign oValid = validQ;
  assign oDec   = decQ;
  assign oRs1   = rs1Q;
  assign oRs2   = rs2Q;

endmodule

// File: tb/tb_instr_decode.sv
module tb_instr_decode;
  import instr_decode_pkg::*;

  logic        iClk;
  logic        iRst;
  logic        iValid;
  logic        oReady;
  logic [31:0] iInstr;
  logic [31:0] iPc;
  logic        iFlush;
  logic        oValid;
  logic        iReady;
  tDecOp       oDec;
  tRegOp       oRs1;
  tRegOp       oRs2;

  int chkCnt = 0;
  int errCnt = 0;
  logic [31:0] issued [$];

  instr_decode dut (
    .iClk  (iClk),
    .iRst  (iRst),
    .iValid(iValid),
    .oReady(oReady),
    .iInstr(iInstr),
    .iPc   (iPc),
    .iFlush(iFlush),
    .oValid(oValid),
    .iReady(iReady),
    .oDec  (oDec),
    .oRs1  (oRs1),
    .oRs2  (oRs2)
  );

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  task automatic cmpv(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chkCnt++;
    if (act !== exp) begin
      errCnt++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    tDecOp dec;
    tRegOp rs1;
    tRegOp rs2;
  } tExp;

  function automatic tExp modelDecode(input logic [31:0] w, input logic [31:0] pc);
    tExp         x;
    logic [31:0] immI, immS, immB, immU, immJ, imm;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd, r1, r2;
    bit          hasRd, hasR1, hasR2, usesImm, ok;
    bit          ld, st, br, jal, jalr, lui, auipc;
    tAluOp       alu;
    tAluOp       aluTab [8];
    aluTab = '{AluAdd, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluOr, AluAnd};
    f3 = w[14:12]; f7 = w[31:25]; rd = w[11:7]; r1 = w[19:15]; r2 = w[24:20];
    // Immediates built arithmetically from the I-type sign extension.
    immI = 32'($signed(w) >>> 20);
    immS = (immI & ~32'h1F) | 32'(rd);
    immB = (immS & ~32'h801) | (32'(w[7]) << 11);
    immU = w & 32'hFFFF_F000;
    immJ = (immI & 32'hFFF0_07FE) | (w & 32'h000F_F000) | (32'(w[20]) << 11);
    hasRd = 0; hasR1 = 0; hasR2 = 0; usesImm = 0; ok = 1; imm = 0; alu = AluAdd;
    ld = 0; st = 0; br = 0; jal = 0; jalr = 0; lui = 0; auipc = 0;
    case (w[6:0])
      7'b0110111: begin hasRd = 1; usesImm = 1; imm = immU; lui = 1; end
      7'b0010111: begin hasRd = 1; usesImm = 1; imm = immU; auipc = 1; end
      7'b1101111: begin hasRd = 1; usesImm = 1; imm = immJ; jal = 1; end
      7'b1100111: begin hasRd = 1; hasR1 = 1; usesImm = 1; imm = immI; jalr = 1; ok = (f3 == 0); end
      7'b1100011: begin hasR1 = 1; hasR2 = 1; imm = immB; br = 1; alu = AluSub; ok = (f3 != 2 && f3 != 3); end
      7'b0000011: begin
        hasRd = 1; hasR1 = 1; usesImm = 1; imm = immI; ld = 1;
        ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
      end
      7'b0100011: begin hasR1 = 1; hasR2 = 1; usesImm = 1; imm = immS; st = 1; ok = (f3 <= 2); end
      7'b0010011: begin
        hasRd = 1; hasR1 = 1; usesImm = 1; imm = immI; alu = aluTab[f3];
        if (f3 == 1) ok = (f7 == 0);
        if (f3 == 5) begin
          ok = (f7 == 0) || (f7 == 7'h20);
          if (f7 == 7'h20) alu = AluSra;
        end
      end
      7'b0110011: begin
        hasRd = 1; hasR1 = 1; hasR2 = 1; alu = aluTab[f3];
        if (f7 == 7'h20) begin
          if (f3 == 0) alu = AluSub;
          else if (f3 == 5) alu = AluSra;
          else ok = 0;
        end else if (f7 != 0) ok = 0;
      end
      7'b0001111: ;
      default: ok = 0;
    endcase
    x = '0;
    x.dec.pc = pc;
    if (!ok) begin
      x.dec.illegal = 1;
    end else begin
      x.dec.rdAddr = rd;    x.dec.rdWe = hasRd && (rd != 0);
      x.dec.aluOp = alu;    x.dec.imm = imm;       x.dec.useImm = usesImm;
      x.dec.useRs1 = hasR1; x.dec.useRs2 = hasR2;  x.dec.funct3 = f3;
      x.dec.isLoad = ld;    x.dec.isStore = st;    x.dec.isBranch = br;
      x.dec.isJal = jal;    x.dec.isJalr = jalr;   x.dec.isLui = lui;
      x.dec.isAuipc = auipc;
      x.rs1.dv = hasR1 && (r1 != 0); x.rs1.addr = r1;
      x.rs2.dv = hasR2 && (r2 != 0); x.rs2.addr = r2;
    end
    return x;
  endfunction

  logic mValid;
  tExp  mExp;

  always @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      mValid <= 1'b0;
      mExp   <= '0;
    end else if (iFlush) begin
      mValid <= 1'b0;
      mExp.rs1.dv <= 1'b0;
      mExp.rs2.dv <= 1'b0;
    end else if (iValid && (!mValid || iReady)) begin
      mValid <= 1'b1;
      mExp   <= modelDecode(iInstr, iPc);
    end else if (mValid && iReady) begin
      mValid <= 1'b0;
      mExp.rs1.dv <= 1'b0;
      mExp.rs2.dv <= 1'b0;
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge iClk) begin
    cmpv("oValid", 32'(oValid), 32'(mValid));
    cmpv("oReady", 32'(oReady), 32'(!mValid || iReady));
    cmpv("rs1.dv", 32'(oRs1.dv), 32'(mExp.rs1.dv));
    cmpv("rs2.dv", 32'(oRs2.dv), 32'(mExp.rs2.dv));
    if (mExp.rs1.dv) cmpv("rs1.addr", 32'(oRs1.addr), 32'(mExp.rs1.addr));
    if (mExp.rs2.dv) cmpv("rs2.addr", 32'(oRs2.addr), 32'(mExp.rs2.addr));
    if (mValid) begin
      cmpv("pc", oDec.pc, mExp.dec.pc);
      cmpv("illegal", 32'(oDec.illegal), 32'(mExp.dec.illegal));
      cmpv("rdWe", 32'(oDec.rdWe), 32'(mExp.dec.rdWe));
      cmpv("isLoad", 32'(oDec.isLoad), 32'(mExp.dec.isLoad));
      cmpv("isStore", 32'(oDec.isStore), 32'(mExp.dec.isStore));
      cmpv("isBranch", 32'(oDec.isBranch), 32'(mExp.dec.isBranch));
      cmpv("isJal", 32'(oDec.isJal), 32'(mExp.dec.isJal));
      cmpv("isJalr", 32'(oDec.isJalr), 32'(mExp.dec.isJalr));
      if (!mExp.dec.illegal) begin
        cmpv("aluOp", 32'(oDec.aluOp), 32'(mExp.dec.aluOp));
        cmpv("useImm", 32'(oDec.useImm), 32'(mExp.dec.useImm));
        cmpv("useRs1", 32'(oDec.useRs1), 32'(mExp.dec.useRs1));
        cmpv("useRs2", 32'(oDec.useRs2), 32'(mExp.dec.useRs2));
        cmpv("isLui", 32'(oDec.isLui), 32'(mExp.dec.isLui));
        cmpv("isAuipc", 32'(oDec.isAuipc), 32'(mExp.dec.isAuipc));
        cmpv("funct3", 32'(oDec.funct3), 32'(mExp.dec.funct3));
        if (mExp.dec.rdWe) cmpv("rdAddr", 32'(oDec.rdAddr), 32'(mExp.dec.rdAddr));
        if (mExp.dec.useImm || mExp.dec.isBranch) cmpv("imm", oDec.imm, mExp.dec.imm);
      end
    end
    if (oValid && iReady) issued.push_back(oDec.pc);
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input logic v, input logic [31:0] w, input logic [31:0] pc,
                      input logic rdy, input logic fl);
    iValid = v; iInstr = w; iPc = pc; iReady = rdy; iFlush = fl;
    @(posedge iClk);
    #1;
  endtask

  logic [31:0] tabW   [12];
  logic        tabIll [12];
  logic [31:0] expPcs [4];

  initial begin
    tabW   = '{32'hFE20AEE3, 32'h022081B3, 32'h40309093, 32'h00009067, 32'h0040B283,
               32'h0020B423, 32'h0040A283, 32'h008000EF, 32'h00008067, 32'h00001117,
               32'h0FF0000F, 32'h0000A023};
    tabIll = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    expPcs = '{32'h100, 32'h104, 32'h108, 32'h10C};

    iRst = 1'b0; iValid = 0; iInstr = 0; iPc = 0; iReady = 0; iFlush = 0;
    repeat (2) @(posedge iClk);
    #1;
    cmpv("rst.oValid", 32'(oValid), 0);
    cmpv("rst.oDecZero", 32'(oDec == '0), 1);
    cmpv("rst.rs1", 32'(oRs1), 0);
    cmpv("rst.rs2", 32'(oRs2), 0);
    iRst = 1'b1;

    // addi x1,x0,5
    step(1, 32'h00500093, 32'h0, 1, 0);
    cmpv("addi.oValid", 32'(oValid), 1);
    cmpv("addi.rdAddr", 32'(oDec.rdAddr), 1);
    cmpv("addi.rdWe", 32'(oDec.rdWe), 1);
    cmpv("addi.imm", oDec.imm, 32'd5);
    cmpv("addi.useImm", 32'(oDec.useImm), 1);
    cmpv("addi.aluOp", 32'(oDec.aluOp), 32'(AluAdd));
    cmpv("addi.rs1dv", 32'(oRs1.dv), 0);
    cmpv("addi.rs2dv", 32'(oRs2.dv), 0);

    // add x3,x1,x2
    step(1, 32'h002081B3, 32'h4, 1, 0);
    cmpv("add.rs1", 32'(oRs1), 32'h21);
    cmpv("add.rs2", 32'(oRs2), 32'h22);
    cmpv("add.rdAddr", 32'(oDec.rdAddr), 3);
    cmpv("add.aluOp", 32'(oDec.aluOp), 32'(AluAdd));
    cmpv("add.useImm", 32'(oDec.useImm), 0);

    // sw x2,8(x1)
    step(1, 32'h0020A423, 32'h8, 1, 0);
    cmpv("sw.imm", oDec.imm, 32'd8);
    cmpv("sw.isStore", 32'(oDec.isStore), 1);
    cmpv("sw.rdWe", 32'(oDec.rdWe), 0);

    // beq x1,x2,-4
    step(1, 32'hFE208EE3, 32'hC, 1, 0);
    cmpv("beq.imm", oDec.imm, 32'hFFFF_FFFC);
    cmpv("beq.isBranch", 32'(oDec.isBranch), 1);
    cmpv("beq.aluOp", 32'(oDec.aluOp), 32'(AluSub));
    cmpv("beq.rdWe", 32'(oDec.rdWe), 0);
    step(0, 0, 0, 1, 0);

    // Stream with a 3-cycle stall after the first op.
    step(1, 32'h002081B3, 32'h100, 1, 0);
    issued.delete();
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h40208233, 32'h104, 0, 0);
      cmpv("stall.oReady", 32'(oReady), 0);
      cmpv("stall.pc", oDec.pc, 32'h100);
      cmpv("stall.rdAddr", 32'(oDec.rdAddr), 3);
      cmpv("stall.rs1", 32'(oRs1), 32'h21);
      cmpv("stall.rs2", 32'(oRs2), 32'h22);
    end
    step(1, 32'h40208233, 32'h104, 1, 0);
    cmpv("sub.aluOp", 32'(oDec.aluOp), 32'(AluSub));
    step(1, 32'hFFF0C313, 32'h108, 1, 0);
    cmpv("xori.imm", oDec.imm, 32'hFFFF_FFFF);
    step(1, 32'h4030D393, 32'h10C, 1, 0);
    cmpv("srai.aluOp", 32'(oDec.aluOp), 32'(AluSra));
    step(0, 0, 0, 1, 0);
    cmpv("stream.count", 32'(issued.size()), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < issued.size()) cmpv($sformatf("stream.pc%0d", i), issued[i], expPcs[i]);
    end

    // Flush while holding an op with a LUI arriving.
    step(1, 32'h00500093, 32'h200, 0, 0);
    cmpv("fl.preValid", 32'(oValid), 1);
    step(1, 32'h123452B7, 32'h204, 1, 1);
    cmpv("fl.oValid", 32'(oValid), 0);
    step(0, 0, 0, 1, 0);
    cmpv("fl.noLui", 32'(oValid), 0);
    step(1, 32'h123452B7, 32'h208, 1, 0);
    cmpv("lui.oValid", 32'(oValid), 1);
    cmpv("lui.imm", oDec.imm, 32'h1234_5000);
    cmpv("lui.isLui", 32'(oDec.isLui), 1);
    cmpv("lui.rdAddr", 32'(oDec.rdAddr), 5);
    step(0, 0, 0, 1, 0);

    // Flush during a stall.
    step(1, 32'h00500093, 32'h300, 0, 0);
    step(0, 0, 0, 0, 0);
    cmpv("flst.held", oDec.pc, 32'h300);
    step(0, 0, 0, 0, 1);
    cmpv("flst.oValid", 32'(oValid), 0);

    // Illegal words.
    step(1, 32'hFFFF_FFFF, 32'h380, 1, 0);
    cmpv("ill1.oValid", 32'(oValid), 1);
    cmpv("ill1.illegal", 32'(oDec.illegal), 1);
    cmpv("ill1.rdWe", 32'(oDec.rdWe), 0);
    cmpv("ill1.dv", 32'({oRs1.dv, oRs2.dv}), 0);
    step(1, 32'h0000_0000, 32'h384, 1, 0);
    cmpv("ill0.oValid", 32'(oValid), 1);
    cmpv("ill0.illegal", 32'(oDec.illegal), 1);
    cmpv("ill0.rdWe", 32'(oDec.rdWe), 0);
    cmpv("ill0.dv", 32'({oRs1.dv, oRs2.dv}), 0);
    for (int i = 0; i < 12; i++) begin
      step(1, tabW[i], 32'h400 + 32'(4 * i), 1, 0);
      cmpv($sformatf("tab%0d.oValid", i), 32'(oValid), 1);
      cmpv($sformatf("tab%0d.illegal", i), 32'(oDec.illegal), 32'(tabIll[i]));
    end
    step(0, 0, 0, 1, 0);

    // Asynchronous reset while stalled.
    step(1, 32'h002081B3, 32'h500, 0, 0);
    step(0, 0, 0, 0, 0);
    cmpv("ar.preValid", 32'(oValid), 1);
    #2;
    iRst = 1'b0;
    #1;
    cmpv("ar.oValid", 32'(oValid), 0);
    cmpv("ar.dv", 32'({oRs1.dv, oRs2.dv}), 0);
    step(0, 0, 0, 1, 0);
    iRst = 1'b1;
    step(1, 32'h00500093, 32'h600, 1, 0);
    cmpv("post.pc", oDec.pc, 32'h600);
    step(0, 0, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", chkCnt, errCnt);
    $finish;
  end

endmodule
